pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central sequencing unit for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It replaces the single global `pipeline_advance` with per-stage enables, bubble and flush controls. It detects read-after-write hazards with a register-write scoreboard, since the datapath has no forwarding, and squashes wrong-path instructions on taken branches. It also provides a debug halt/step/resume FSM and stall/flush performance counters.

## Interface
- `REG_BYPASS`, default 0: 1 means the reg_file is write-through, so the producer in WB does not block a reader in ID.
- `START_HALTED`, default 0: 1 means the FSM leaves reset in HALTED instead of RUN.
- `CNT_W`, default 32: width of the performance counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `halt_req`  in  1  debug halt request, level-sampled.
- `step_req`  in  1  single-step request; honoured only in HALTED.
- `resume_req`  in  1  return to RUN; honoured only in HALTED.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  source actually read (from the ustore/instruction type).
- `id_rd`  in  5  destination register of the instruction in ID.
- `id_rd_wr`  in  1  instruction in ID writes rd (`reg_file_wr_en`).
- `ex_branch_taken`  in  1  branch resolved taken in EX this cycle.
- `pc_inc_en`  out  1  PC may increment.
- `if_id_en`  out  1  IF/ID register load.
- `if_id_flush`  out  1  IF/ID loads a NOP/bubble.
- `id_ex_en`  out  1  ID/EX register load.
- `id_ex_bubble`  out  1  ID/EX control field loads zero.
- `ex_mem_en`  out  1  EX/MEM register load.
- `mem_wb_en`  out  1  MEM/WB register load.
- `halted`  out  1  FSM is in HALTED.
- `stall_cnt`  out  CNT_W  count of hazard-stall cycles.
- `flush_cnt`  out  CNT_W  count of branch-flush events.

## Operation
- State: FSM `state`, `id_v` (ID holds a real instruction), scoreboard entries `sb_ex`, `sb_mem`, `sb_wb`, each {v, rd, wr}.
- Reset values: state=RUN (HALTED if START_HALTED), `id_v`=0, all sb.v=0, both counters=0.
- Reset outputs in RUN: all enables 1, flush/bubble 0, `halted`=0. In HALTED: all enables 0, `halted`=1.
- `advance` = (state==RUN) or (state==STEP).
- Hazard `haz`: `id_v` and some used rsN≠0 matches an entry with v and wr and rd≠0.
  - Entries checked: `sb_ex`, `sb_mem`, and `sb_wb` only when REG_BYPASS=0.
  - x0 never hazards.
- Priority when `advance`: branch > hazard > normal.
  - Branch (`ex_branch_taken`): `if_id_flush`=1, `id_ex_bubble`=1, all enables 1, `id_v`←0. The ID instruction is wrong-path, so any hazard on it is ignored and is not counted as a stall. `flush_cnt`+1.
  - Hazard: `pc_inc_en`=0, `if_id_en`=0, `id_ex_en`=1 with `id_ex_bubble`=1, EX/MEM and MEM/WB advance, `id_v` unchanged. `stall_cnt`+1.
  - Normal: all enables 1, `id_v`←1.
- Scoreboard shift (only when `advance`): `sb_wb`←`sb_mem`, `sb_mem`←`sb_ex`. `sb_ex`←{id_v, id_rd, id_rd_wr}, or invalid on bubble or flush.
- FSM:
  - RUN → HALTED on `halt_req` (the cycle with `halt_req` still advances).
  - HALTED → STEP on `step_req`. HALTED → RUN on `resume_req`. If both are high, `resume_req` wins.
  - STEP → HALTED unconditionally after exactly one advance cycle. Its hazard and branch rules are identical to RUN.
- In HALTED, all state is frozen except the FSM. Counters do not change.
- Counters wrap modulo 2^CNT_W.

## Timing
- Control outputs are combinational from registered state plus the ID/EX inputs, so the zero-cycle decision is valid in the same cycle.
- RAW penalty with the producer immediately ahead: 3 stall cycles (REG_BYPASS=0) or 2 (REG_BYPASS=1). Producers further ahead cost proportionally fewer.
- Taken branch costs exactly 2 bubbles (IF/ID and ID/EX).
- Halt takes effect the cycle after `halt_req` is sampled. Each step advances exactly one cycle.
- `rst` mid-operation: all state returns to reset values on the next edge. Pending stalls and flushes are dropped.

## Structure
- `riscv_pkg`: `ctrl_state_e` {RUN, HALTED, STEP}, `sb_entry_t` {v, rd[4:0], wr}, `REG_ADDR_W`=5.
- Sub-module `hazard_scoreboard`: holds the three `sb_*` entries and shift logic, and outputs `haz`. `pipeline_ctrl` holds the FSM, priority logic and counters.

## Test plan
- `add x5` in ID then `add x6,x5,x1` next, REG_BYPASS=0 → 3 cycles of `if_id_en`=0 and `id_ex_bubble`=1; `stall_cnt`=3.
- Same sequence with REG_BYPASS=1 → 2 stall cycles; `stall_cnt`=2.
- Producer writes x0 and consumer reads x0 → no stall. Producer with `id_rd_wr`=0 (`sw`) → no stall.
- `ex_branch_taken` while ID holds a hazarding instruction → `if_id_flush`=1, `id_ex_bubble`=1, `pc_inc_en`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- `halt_req` pulse, then `step_req` twice, then `resume_req` → `halted`=1; exactly 2 advance cycles in which the scoreboard shifts twice; then RUN.
- `rst` asserted during a 3-cycle stall → next cycle all enables 1, scoreboard empty, counters 0, `id_v`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the pipeline sequencing unit.
//   ctrl_state_e : debug FSM states (run, halted, single-step)
//   sb_entry_t   : one scoreboard slot {valid, destination register, writes-rd}
//   sb_hit       : true when an entry will write a given non-zero source register
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    StRun,
    StHalted,
    StStep
  } ctrl_state_e;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
  } sb_entry_t;

  // rd != 0 also guarantees rs != 0 on a match, so x0 never hazards.
  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.v && e.wr && (e.rd != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard tracking the destinations of the instructions in EX, MEM and WB.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_advance         : pipeline moves this cycle (shift the scoreboard)
//   i_kill            : slot entering EX is a bubble or flush (insert an invalid entry)
//   i_id_v            : ID holds a real instruction
//   i_id_rd/_rd_wr    : destination of the ID instruction and whether it writes it
//   i_rs1/_rs2(_used) : source registers of the ID instruction and whether they are read
//   o_haz             : read-after-write hazard on the ID instruction
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter bit REG_BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_advance,
  input  logic                  i_kill,
  input  logic                  i_id_v,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rd_wr,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic                  i_rs1_used,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_rs2_used,
  output logic                  o_haz
);

  sb_entry_t r_sb_ex, r_sb_mem, r_sb_wb;
  logic      w_hit1, w_hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_ex  <= '0;
      r_sb_mem <= '0;
      r_sb_wb  <= '0;
    end else if (i_advance) begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= r_sb_ex;
      if (i_kill) begin
        r_sb_ex <= '0;
      end else begin
        r_sb_ex <= '{v: i_id_v, rd: i_id_rd, wr: i_id_rd_wr};
      end
    end
  end

  // With a write-through register file the WB producer is already visible to ID.
  always_comb begin
    w_hit1 = i_rs1_used && (sb_hit(r_sb_ex, i_rs1) || sb_hit(r_sb_mem, i_rs1) ||
                            (!REG_BYPASS && sb_hit(r_sb_wb, i_rs1)));
    w_hit2 = i_rs2_used && (sb_hit(r_sb_ex, i_rs2) || sb_hit(r_sb_mem, i_rs2) ||
                            (!REG_BYPASS && sb_hit(r_sb_wb, i_rs2)));
    o_haz  = i_id_v && (w_hit1 || w_hit2);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencing unit of the 5-stage pipeline: per-stage enables, bubble/flush control,
// RAW hazard stalls, taken-branch squash, debug halt/step/resume FSM and perf counters.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   halt_req, step_req, resume_req : debug controls (step/resume honoured only when halted)
//   id_rs1/2, id_rs1/2_used        : ID source registers and read flags
//   id_rd, id_rd_wr                : ID destination register and write flag
//   ex_branch_taken                : branch in EX resolved taken
//   pc_inc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en : controls
//   halted                         : FSM is halted
//   stall_cnt, flush_cnt           : hazard-stall cycles and branch-flush events (wrapping)
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter bit          REG_BYPASS   = 1'b0,
  parameter bit          START_HALTED = 1'b0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  resume_req,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_wr,
  input  logic                  ex_branch_taken,
  output logic                  pc_inc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam ctrl_state_e ResetState = START_HALTED ? StHalted : StRun;

  ctrl_state_e      r_state, w_state_next;
  logic             r_id_v, w_id_v_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_advance, w_haz, w_stall_inc, w_flush_inc;

  assign w_advance = (r_state == StRun) || (r_state == StStep);

  hazard_scoreboard #(
    .REG_BYPASS (REG_BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_advance  (w_advance),
    .i_kill     (id_ex_bubble),
    .i_id_v     (r_id_v),
    .i_id_rd    (id_rd),
    .i_id_rd_wr (id_rd_wr),
    .i_rs1      (id_rs1),
    .i_rs1_used (id_rs1_used),
    .i_rs2      (id_rs2),
    .i_rs2_used (id_rs2_used),
    .o_haz      (w_haz)
  );

  always_comb begin
    pc_inc_en    = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    halted       = (r_state == StHalted);
    w_id_v_next  = r_id_v;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    if (w_advance) begin
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      id_ex_en  = 1'b1;
      if (ex_branch_taken) begin
        // ID is wrong-path: squash it even if it also hazards, and do not count a stall.
        pc_inc_en    = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        w_id_v_next  = 1'b0;
        w_flush_inc  = 1'b1;
      end else if (w_haz) begin
        // Hold IF and ID, push a bubble into EX so older instructions drain.
        id_ex_bubble = 1'b1;
        w_stall_inc  = 1'b1;
      end else begin
        pc_inc_en   = 1'b1;
        if_id_en    = 1'b1;
        w_id_v_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:    if (halt_req) w_state_next = StHalted;
      StHalted: begin
        if (resume_req) begin
          w_state_next = StRun;
        end else if (step_req) begin
          w_state_next = StStep;
        end
      end
      StStep:   w_state_next = StHalted;
      default:  w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ResetState;
      r_id_v      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_id_v  <= w_id_v_next;
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
